// File: rtl/pwm_fader.sv
// pwm_fader: host-programmable fader that walks a "current" brightness toward
// a "target" value at a fixed tick rate, writing every intermediate value to a
// downstream PWM channel and waiting for that write to be acknowledged.
module pwm_fader #(
  parameter int pClkHz  = 8,
  parameter int pStepHz = 2
) (
  input  logic       clk,
  input  logic       rst,
  // host side request / response
  input  logic       wb_c_stb,
  input  logic       wb_c_we,
  input  logic [1:0] wb_c_adr,
  input  logic [7:0] wb_c_dat,
  output logic       wb_p_ack,
  output logic [7:0] wb_p_dat,
  // downstream PWM channel request / response
  output logic       pwm_c_stb,
  output logic       pwm_c_we,
  output logic [1:0] pwm_c_adr,
  output logic [7:0] pwm_c_dat,
  input  logic       pwm_p_ack
);

  localparam int pTicksPerStep = (pStepHz > 0) ? (pClkHz / pStepHz) : 0;
  localparam int DIV_W         = (pTicksPerStep > 1) ? $clog2(pTicksPerStep) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(pTicksPerStep - 1);

  generate
    if (pTicksPerStep < 1) begin : g_bad_rate
      $error("pwm_fader: pClkHz / pStepHz must be >= 1");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, PUSH = 1'b1} state_t;

  localparam logic [1:0] ADR_TARGET  = 2'd0;
  localparam logic [1:0] ADR_STEP    = 2'd1;
  localparam logic [1:0] ADR_CURRENT = 2'd2;
  localparam logic [1:0] ADR_STATUS  = 2'd3;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [7:0]       target, step, current;
  logic [7:0]       diff, delta, current_nxt;
  logic             load_cur;
  logic             busy;
  logic             host_wr;

  assign tick    = (div_cnt == DIV_LAST);
  assign host_wr = wb_c_stb & wb_c_we;
  assign busy    = (state == PUSH) | (current != target);

  // free-running tick divider, independent of FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                         div_cnt <= div_cnt + 1'b1;
  end

  // host-writable registers; current/status addresses are read-only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target <= 8'h00;
      step   <= 8'h01;
    end else if (host_wr) begin
      if (wb_c_adr == ADR_TARGET) target <= wb_c_dat;
      if (wb_c_adr == ADR_STEP)   step   <= wb_c_dat;
    end
  end

  // clamped step toward target: step 0 or a step larger than the gap lands
  // exactly on target, so current can never overshoot or wrap
  always_comb begin
    diff        = (target >= current) ? (target - current) : (current - target);
    delta       = ((step == 8'h00) || (step > diff)) ? diff : step;
    current_nxt = (target >= current) ? (current + delta) : (current - delta);
  end

  // current only moves on a qualifying tick in IDLE; it is frozen in PUSH so
  // the downstream data stays stable until acknowledged
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           current <= 8'h00;
    else if (load_cur) current <= current_nxt;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state and downstream outputs; ticks seen in PUSH are dropped
  always_comb begin
    state_nxt = state;
    load_cur  = 1'b0;
    pwm_c_stb = 1'b0;
    pwm_c_we  = 1'b0;
    pwm_c_adr = 2'd0;
    pwm_c_dat = 8'h00;
    case (state)
      IDLE: begin
        if (tick && (current != target)) begin
          load_cur  = 1'b1;
          state_nxt = PUSH;
        end
      end
      PUSH: begin
        pwm_c_stb = 1'b1;
        pwm_c_we  = 1'b1;
        pwm_c_dat = current;
        if (pwm_p_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // zero-wait-state host read mux; data bus is quiet when not strobed
  always_comb begin
    wb_p_ack = wb_c_stb;
    wb_p_dat = 8'h00;
    if (wb_c_stb) begin
      case (wb_c_adr)
        ADR_TARGET:  wb_p_dat = target;
        ADR_STEP:    wb_p_dat = step;
        ADR_CURRENT: wb_p_dat = current;
        ADR_STATUS:  wb_p_dat = {7'b0, busy};
        default:     wb_p_dat = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fader.sv
// tb_pwm_fader: register-access vector table plus fade sequences; every
// downstream push is compared against a queue filled by a reference model.
module tb_pwm_fader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wb_c_stb = 1'b0, wb_c_we = 1'b0;
  logic [1:0] wb_c_adr = 2'd0;
  logic [7:0] wb_c_dat = 8'h00;
  logic       wb_p_ack;
  logic [7:0] wb_p_dat;
  logic       pwm_c_stb, pwm_c_we;
  logic [1:0] pwm_c_adr;
  logic [7:0] pwm_c_dat;
  logic       pwm_p_ack = 1'b0;

  pwm_fader #(.pClkHz(8), .pStepHz(2)) dut (
    .clk(clk), .rst(rst),
    .wb_c_stb(wb_c_stb), .wb_c_we(wb_c_we), .wb_c_adr(wb_c_adr), .wb_c_dat(wb_c_dat),
    .wb_p_ack(wb_p_ack), .wb_p_dat(wb_p_dat),
    .pwm_c_stb(pwm_c_stb), .pwm_c_we(pwm_c_we), .pwm_c_adr(pwm_c_adr), .pwm_c_dat(pwm_c_dat),
    .pwm_p_ack(pwm_p_ack)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         ack_delay = 1;
  int         ack_cnt = 0;
  logic [7:0] mcur = 8'h00, mtgt = 8'h00, mstep = 8'h01;
  logic       prev_stb = 1'b0;
  logic [7:0] held = 8'h00;
  int         hold_len = 0;
  int         last_len = 0;

  typedef struct {
    logic       we;
    logic [1:0] adr;
    logic [7:0] dat;   // write data, or expected read data
    string      name;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // reference fade: every value the channel should see for the current goal
  task automatic model_fade();
    logic [7:0] gap, d;
    while (mcur != mtgt) begin
      gap = (mtgt > mcur) ? mtgt - mcur : mcur - mtgt;
      d   = (mstep == 0 || mstep > gap) ? gap : mstep;
      mcur = (mtgt > mcur) ? mcur + d : mcur - d;
      exp_q.push_back(mcur);
    end
  endtask

  task automatic bus(input logic we, input logic [1:0] a, input logic [7:0] d,
                     output logic [7:0] r);
    @(posedge clk); #1;
    wb_c_stb = 1'b1; wb_c_we = we; wb_c_adr = a; wb_c_dat = d;
    @(negedge clk);
    r = wb_p_dat;
    check("host_ack", {7'b0, wb_p_ack}, 8'h01);
    @(posedge clk); #1;
    wb_c_stb = 1'b0; wb_c_we = 1'b0; wb_c_dat = 8'h00;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] r;
    bus(1'b1, a, d, r);
    if (a == 2'd1) mstep = d;
    if (a == 2'd0) begin mtgt = d; model_fade(); end
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string name);
    logic [7:0] r;
    bus(1'b0, a, 8'h00, r);
    check(name, r, e);
  endtask

  task automatic run_table(input vec_t v[]);
    foreach (v[i]) begin
      if (v[i].we) wr(v[i].adr, v[i].dat);
      else         rd(v[i].adr, v[i].dat, v[i].name);
    end
  endtask

  // poll status until not busy and all expected pushes seen, bounded
  task automatic wait_idle(input string name);
    logic [7:0] r;
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      bus(1'b0, 2'd3, 8'h00, r);
      if (r == 8'h00 && exp_q.size() == 0) done = 1;
    end
    check({name, "_done"}, {7'b0, done}, 8'h01);
    rd(2'd3, 8'h00, {name, "_busy"});
    rd(2'd2, mcur, {name, "_current"});
  endtask

  // downstream responder: ack after ack_delay cycles of stb
  always @(posedge clk) begin
    #1;
    if (!pwm_c_stb) begin ack_cnt = 0; pwm_p_ack = 1'b0; end
    else begin ack_cnt++; pwm_p_ack = (ack_cnt > ack_delay); end
  end

  // push monitor / scoreboard
  always @(negedge clk) begin
    if (rst) prev_stb = 1'b0;
    else begin
      if (pwm_c_stb) begin
        check("push_we", {7'b0, pwm_c_we}, 8'h01);
        check("push_adr", {6'b0, pwm_c_adr}, 8'h00);
        if (!prev_stb) begin
          held = pwm_c_dat; hold_len = 0;
          check("push_expected", {7'b0, exp_q.size() != 0}, 8'h01);
        end else check("push_stable", pwm_c_dat, held);
        hold_len++;
        if (pwm_p_ack && exp_q.size() != 0) begin
          check("push_data", pwm_c_dat, exp_q.pop_front());
          last_len = hold_len;
        end
      end
      prev_stb = pwm_c_stb;
    end
  end

  initial begin
    vec_t reset_vecs[];
    vec_t reg_vecs[];
    logic seen;
    reset_vecs = '{
      '{1'b0, 2'd0, 8'h00, "rst_target"},
      '{1'b0, 2'd1, 8'h01, "rst_step"},
      '{1'b0, 2'd2, 8'h00, "rst_current"},
      '{1'b0, 2'd3, 8'h00, "rst_status"}
    };
    reg_vecs = '{
      '{1'b1, 2'd2, 8'h55, ""},
      '{1'b1, 2'd3, 8'h77, ""},
      '{1'b0, 2'd2, 8'h00, "ro_current"},
      '{1'b0, 2'd3, 8'h00, "ro_status"},
      '{1'b1, 2'd1, 8'h05, ""},
      '{1'b0, 2'd1, 8'h05, "rw_step"},
      '{1'b1, 2'd1, 8'h01, ""},
      '{1'b1, 2'd0, 8'h00, ""},
      '{1'b0, 2'd0, 8'h00, "rw_target_eq_cur"},
      '{1'b0, 2'd3, 8'h00, "no_push_status"}
    };

    repeat (2) @(negedge clk);
    check("rst_pwm_stb", {7'b0, pwm_c_stb}, 8'h00);
    check("rst_pwm_dat", pwm_c_dat, 8'h00);
    check("rst_wb_dat", wb_p_dat, 8'h00);
    @(posedge clk); #1 rst = 1'b0;

    run_table(reset_vecs);
    run_table(reg_vecs);

    // slow ramp 0 -> 3, step 1
    wr(2'd0, 8'h03);
    rd(2'd3, 8'h01, "ramp_busy");
    wait_idle("ramp");
    repeat (12) @(posedge clk);

    // coarse ramp with a clamped final step
    wr(2'd1, 8'h10);
    wr(2'd0, 8'hFA);
    wait_idle("coarse");

    // jump back to zero
    wr(2'd1, 8'h00);
    wr(2'd0, 8'h00);
    wait_idle("jump");

    // slow downstream: data must hold through a long ack wait
    ack_delay = 10;
    wr(2'd1, 8'h01);
    wr(2'd0, 8'h02);
    wait_idle("holdoff");
    check("holdoff_len", 8'(last_len), 8'd11);
    ack_delay = 1;

    // asynchronous reset in the middle of a push
    wr(2'd0, 8'h80);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = pwm_c_stb;
    end
    check("abort_stb_seen", {7'b0, seen}, 8'h01);
    #2 rst = 1'b1;
    #1;
    check("abort_stb_async", {7'b0, pwm_c_stb}, 8'h00);
    check("abort_dat_async", pwm_c_dat, 8'h00);
    exp_q.delete();
    mcur = 8'h00; mtgt = 8'h00; mstep = 8'h01;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run_table(reset_vecs);
    repeat (10) @(posedge clk);
    rd(2'd2, 8'h00, "abort_no_retry");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pwm_fader.md
PWM_FADER -- requirements
Module: pwm_fader

Interface
REQ-001 pClkHz, 0, system clock frequency in Hz.
REQ-002 pStepHz, 0, fade step rate in Hz; pTicksPerStep = pClkHz / pStepHz SHALL be >= 1 (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wb_c  input  iWishbone_Ctrl  host-side request; fields used: stb, we, adr[1:0], dat[7:0].
REQ-006 wb_p  output  iWishbone_Peri  host-side response; fields used: ack, dat[7:0].
REQ-007 pwm_c  output  iWishbone_Ctrl  downstream write to one PWM channel; fields used: stb, we, dat[7:0]; adr driven 0.
REQ-008 pwm_p  input  iWishbone_Peri  downstream response; field used: ack.

Function
REQ-009 Register map on wb_c.adr: 0 target (RW), 1 step (RW), 2 current (RO), 3 status (RO, bit0 = busy, bits7:1 = 0).
REQ-010 wb_p.ack SHALL equal wb_c.stb combinationally; zero wait states.
REQ-011 Reads: wb_p.dat SHALL present the addressed register in the same cycle as ack; wb_p.dat = 0 when stb low.
REQ-012 Writes (stb & we): adr 0 or 1 updates the register at the clock edge; writes to adr 2 or 3 are ignored.
REQ-013 Tick divider: counter 0..pTicksPerStep-1, width $clog2(pTicksPerStep) (min 1); tick pulses 1 cycle when counter = pTicksPerStep-1, then wraps to 0; free-running in all states.
REQ-014 FSM states: IDLE, PUSH.
REQ-015 IDLE, tick, current != target: current moves toward target by min(step, |target - current|), state -> PUSH on the same edge.
REQ-016 step = 0 means jump: on the qualifying tick, current <= target.
REQ-017 Arithmetic is 8-bit unsigned with no overshoot and no wrap; current never crosses target.
REQ-018 IDLE, tick, current = target: no action, stays IDLE.
REQ-019 PUSH: pwm_c.stb = 1, pwm_c.we = 1, pwm_c.dat = current, held stable until pwm_p.ack.
REQ-020 PUSH with pwm_p.ack = 1: state -> IDLE at that edge; pwm_c.stb = 0 in IDLE.
REQ-021 Ticks occurring in PUSH are dropped, not queued; current is frozen while in PUSH.
REQ-022 Host writes to target/step during PUSH are accepted immediately; they take effect at the first tick after return to IDLE.
REQ-023 Host write on the same edge as a qualifying tick: the step computation uses the pre-write target and step.
REQ-024 busy = (state = PUSH) or (current != target).
REQ-025 A host write of target equal to current issues no downstream transaction.

Reset
REQ-026 On rst, asynchronously: target = 0, step = 1, current = 0, divider = 0, state = IDLE.
REQ-027 Reset outputs: pwm_c.stb = 0, pwm_c.dat = 0, wb_p.dat = 0 while wb_c.stb is low.
REQ-028 rst asserted in PUSH aborts the transaction immediately; no retry after release.
REQ-029 After release, the first tick occurs pTicksPerStep cycles later.

Verification (pClkHz = 8, pStepHz = 2, so tick every 4 cycles; downstream acks 1 cycle after stb)
REQ-030 Reset release, then read adr 0/1/2/3 -> 0x00/0x01/0x00/0x00; pwm_c.stb is never asserted.
REQ-031 Write target = 0x03, step = 1 -> pushes 0x01, 0x02, 0x03 on consecutive ticks; then busy = 0 and no further stb.
REQ-032 From current = 0x03: write step = 0x10, target = 0xFA -> pushes 0x13, 0x23, ..., 0xF3, 0xFA; last step is clamped and there is no wrap.
REQ-033 Write step = 0, target = 0x00 from current = 0xFA -> a single push of 0x00 on the next tick.
REQ-034 Downstream ack held off for 10 cycles -> pwm_c.dat is stable throughout; the 2 ticks in that window are dropped; current advances exactly once per completed push.
REQ-035 Assert rst while pwm_c.stb = 1 -> stb drops without waiting for a clock edge; all registers read reset values after release.
